mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage. Sits between the EX/MEM register and the MEM/WB register.
- Drives a handshaked data-memory bus (req/ack, variable latency) for loads and stores, and aligns/extends load data.
- Stalls the pipeline while an access is outstanding.
- Presents WB control, rd, load data and ALU address to the MEM/WB register, which has no enable; stall cycles are therefore emitted as bubbles.

Parameters:
- TIMEOUT, default 255: max BUSY cycles without dm_ack before abort; legal range 1..65535.
- CNT_W, default 16: width of the timeout counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- EX_M  input  2  [1]=MemRead, [0]=MemWrite
- EX_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- EX_unsigned  input  1  zero-extend loads when 1
- EX_WB  input  2  writeback control
- EX_rd  input  5  destination register
- EX_aluResult  input  32  effective address / ALU result
- EX_writeData  input  32  store data, right-justified
- dm_req  output  1  memory request, registered
- dm_we  output  1  write strobe, registered
- dm_addr  output  32  word address {addr[31:2],2'b00}, registered
- dm_be  output  4  byte enables, registered
- dm_wdata  output  32  lane-replicated store data, registered
- dm_rdata  input  32  read data, valid with dm_ack
- dm_ack  input  1  one-cycle completion
- stall  output  1  hold PC/IF/ID/EX/MEM, combinational
- misalign  output  1  one-cycle pulse, registered
- bus_err  output  1  one-cycle pulse on timeout, registered
- MEM_WB  output  2  to MEM/WB register
- MEM_rd  output  5
- MEM_data  output  32  load result
- MEM_address  output  32  pass-through of EX_aluResult

Behaviour:
- Reset:
  - State IDLE; dm_req=0, dm_we=0, dm_addr=0, dm_be=0, dm_wdata=0.
  - misalign=0, bus_err=0, load register=0, counter=0.
  - Combinational outputs follow from IDLE.
- Memory op: mem_op = EX_M[1]|EX_M[0]. If both bits are set, it is a store.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. Byte lanes are little-endian; lane = addr[1:0].
- State machine:
  - IDLE:
    - No mem_op: stall=0; outputs pass EX_WB/EX_rd/EX_aluResult; MEM_data=0. Zero-latency pass-through.
    - mem_op, misaligned: no request; stall=0; MEM_WB=00, MEM_rd=0; misalign=1 next cycle; stay IDLE.
    - mem_op, aligned: stall=1; MEM_WB=00, MEM_rd=0 (bubble). Next edge: load dm_* registers, dm_req=1, counter=0, go BUSY.
  - BUSY:
    - stall=1; bubble outputs; dm_req held with stable dm_* fields.
    - dm_ack=1: dm_req=0; capture the extended load into the load register (stores capture 0); go DONE.
    - Else counter+1. When counter reaches TIMEOUT-1 without ack: dm_req=0, bus_err pulse, go ABORT.
    - dm_ack in the same cycle as the last timeout count: the ack wins.
  - DONE: stall=0; MEM_WB=EX_WB; MEM_rd=EX_rd; MEM_data=load register; MEM_address=EX_aluResult. Next edge: go IDLE unconditionally.
  - ABORT: stall=0; MEM_WB=00, MEM_rd=0 (instruction killed). Next edge: go IDLE.
- Byte enables and store data:
  - Byte: be=0001<<lane; wdata={4{wd[7:0]}}.
  - Half: be=0011<<lane; wdata={2{wd[15:0]}}.
  - Word: be=1111; wdata=wd.
  - Loads use the same be; dm_we=0.
- Load extraction: select the byte/half at the lane, then sign- or zero-extend to 32 per EX_unsigned. Word loads pass through unchanged.
- Stray dm_ack in IDLE/DONE/ABORT is ignored.
- Async reset mid-BUSY: dm_req drops immediately; the access is abandoned.
- Minimum aligned access cost: 2 stall cycles (IDLE + BUSY with immediate ack).

Decomposition:
- Shared package mips_mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum (IDLE/BUSY/DONE/ABORT), M-bit indices.
- One sub-module, load_align: combinational lane select plus sign/zero extend (rdata, lane, size, unsigned -> data32). Reused by the store-lane generator only as constants.

Test Plan:
- Non-memory op (EX_M=00, WB=10, rd=5, alu=0x1234) -> same cycle MEM_WB=10, MEM_rd=5, MEM_address=0x1234, MEM_data=0, stall=0, dm_req never 1.
- LB signed at addr 0x103, ack after 3 BUSY cycles with rdata=0x80FF_FF00 -> dm_be=1000, stall high 4 cycles, DONE MEM_data=0xFFFF_FF80. Then with EX_unsigned=1 -> 0x0000_0080.
- SH addr 0x202, wd=0xABCD_1234, immediate ack -> dm_we=1, dm_addr=0x200, dm_be=1100, dm_wdata=0x1234_1234, exactly 2 stall cycles.
- LW at 0x105 -> no dm_req, misalign pulses one cycle, MEM_WB=00, stall=0.
- TIMEOUT=4, LW with no ack -> dm_req 4 cycles, bus_err pulse, ABORT outputs MEM_WB=00, then IDLE. Repeat with ack in the 4th cycle -> DONE, no bus_err.
- Assert rst=0 during BUSY -> dm_req=0 immediately; after release, state IDLE and all outputs at reset values.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MEM pipeline stage: access-size encodings, the
// bus FSM state type, EX_M bit positions, and helpers that derive the
// alignment check, byte enables and lane-replicated store data from
// (size, lane).
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Bit positions inside EX_M
    localparam int M_READ  = 1;
    localparam int M_WRITE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        ABORT = 2'b11
    } state_t;

    // Half needs an even address, word (and the reserved code) needs 4-byte
    // alignment; bytes are always aligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lane[0];
            SZ_WORD: ok = (lane == 2'b00);
            default: ok = (lane == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated across every lane so the memory only has to
    // honour the byte enables.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wd[7:0]}};
            SZ_HALF: d = {2{wd[15:0]}};
            SZ_WORD: d = wd;
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data aligner: selects the byte or halfword at the given
// lane of a little-endian 32-bit read word and sign- or zero-extends it.
// Word (and reserved) sizes pass the read word through unchanged.
//   rdata       in  32  raw word from the data memory
//   lane        in   2  byte offset of the access (address[1:0])
//   size        in   2  access size encoding
//   is_unsigned in   1  1 = zero-extend, 0 = sign-extend
//   data        out 32  aligned, extended load value
// -----------------------------------------------------------------------------
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_val;
    logic signed [15:0] half_val;

    // Move the addressed lane down to bit 0
    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        byte_val = shifted[7:0];
        half_val = shifted[15:0];
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            SZ_HALF: data = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage between EX/MEM and MEM/WB. Runs loads/stores over a
// req/ack data-memory bus with variable latency, stalls upstream stages
// while an access is outstanding, and emits bubbles to MEM/WB (which has no
// enable) during stall cycles. Misaligned accesses and bus timeouts kill the
// instruction and raise a one-cycle pulse.
//   clk, rst          clock (rising edge), async active-low reset
//   EX_M              [1]=MemRead [0]=MemWrite (both set -> store)
//   EX_size           00 byte, 01 half, 10 word, 11 treated as word
//   EX_unsigned       zero-extend loads
//   EX_WB, EX_rd      writeback control / destination register
//   EX_aluResult      effective address, also passed through
//   EX_writeData      right-justified store data
//   dm_req/we/addr/be/wdata  registered memory request fields
//   dm_rdata, dm_ack  read data and one-cycle completion
//   stall             combinational hold for PC/IF/ID/EX/MEM
//   misalign, bus_err registered one-cycle error pulses
//   MEM_WB, MEM_rd, MEM_data, MEM_address  to MEM/WB register
// -----------------------------------------------------------------------------
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  EX_M,
    input  logic [1:0]  EX_size,
    input  logic        EX_unsigned,
    input  logic [1:0]  EX_WB,
    input  logic [4:0]  EX_rd,
    input  logic [31:0] EX_aluResult,
    input  logic [31:0] EX_writeData,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic [1:0]  MEM_WB,
    output logic [4:0]  MEM_rd,
    output logic [31:0] MEM_data,
    output logic [31:0] MEM_address
);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        load_q;

    // Access attributes latched at request time so load extraction does not
    // depend on the upstream register holding steady.
    logic [1:0]         req_lane;
    logic [1:0]         req_size;
    logic               req_uns;
    logic               req_load;

    logic               mem_op;
    logic               is_store;
    logic [1:0]         lane;
    logic               aligned;
    logic               timeout_hit;
    logic [31:0]        align_data;

    assign mem_op      = EX_M[M_READ] | EX_M[M_WRITE];
    assign is_store    = EX_M[M_WRITE];
    assign lane        = EX_aluResult[1:0];
    assign aligned     = is_aligned(EX_size, lane);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    load_align u_load_align (
        .rdata       (dm_rdata),
        .lane        (req_lane),
        .size        (req_size),
        .is_unsigned (req_uns),
        .data        (align_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        stall       = 1'b0;
        MEM_WB      = EX_WB;
        MEM_rd      = EX_rd;
        MEM_data    = 32'h0;
        MEM_address = EX_aluResult;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    // Either a killed misaligned access or the first bubble
                    MEM_WB = 2'b00;
                    MEM_rd = 5'd0;
                    if (aligned) begin
                        stall    = 1'b1;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                stall  = 1'b1;
                MEM_WB = 2'b00;
                MEM_rd = 5'd0;
                // An ack on the final count still completes the access
                if (dm_ack) begin
                    state_nx = DONE;
                end else if (timeout_hit) begin
                    state_nx = ABORT;
                end
            end
            DONE: begin
                MEM_data = load_q;
                state_nx = IDLE;
            end
            ABORT: begin
                MEM_WB   = 2'b00;
                MEM_rd   = 5'd0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'h0;
            dm_be    <= 4'h0;
            dm_wdata <= 32'h0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            load_q   <= 32'h0;
            cnt      <= '0;
            req_lane <= 2'b00;
            req_size <= 2'b00;
            req_uns  <= 1'b0;
            req_load <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_op && !aligned) begin
                        misalign <= 1'b1;
                    end else if (mem_op) begin
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_addr  <= {EX_aluResult[31:2], 2'b00};
                        dm_be    <= byte_en(EX_size, lane);
                        dm_wdata <= store_data(EX_size, EX_writeData);
                        cnt      <= '0;
                        req_lane <= lane;
                        req_size <= EX_size;
                        req_uns  <= EX_unsigned;
                        req_load <= ~is_store;
                    end
                end
                BUSY: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        load_q <= req_load ? align_data : 32'h0;
                    end else if (timeout_hit) begin
                        dm_req  <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  EX_M;
    logic [1:0]  EX_size;
    logic        EX_unsigned;
    logic [1:0]  EX_WB;
    logic [4:0]  EX_rd;
    logic [31:0] EX_aluResult;
    logic [31:0] EX_writeData;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic [1:0]  MEM_WB;
    logic [4:0]  MEM_rd;
    logic [31:0] MEM_data;
    logic [31:0] MEM_address;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .EX_M         (EX_M),
        .EX_size      (EX_size),
        .EX_unsigned  (EX_unsigned),
        .EX_WB        (EX_WB),
        .EX_rd        (EX_rd),
        .EX_aluResult (EX_aluResult),
        .EX_writeData (EX_writeData),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_be        (dm_be),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_ack       (dm_ack),
        .stall        (stall),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .MEM_WB       (MEM_WB),
        .MEM_rd       (MEM_rd),
        .MEM_data     (MEM_data),
        .MEM_address  (MEM_address)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a & 32'd3) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n;
        int ln;
        n  = nbytes(sz);
        ln = int'(a & 32'd3);
        return 4'(((1 << n) - 1) << ln);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = nbytes(sz);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
        int n;
        int ln;
        logic [31:0] mask;
        logic [31:0] v;
        n  = nbytes(sz);
        ln = int'(a & 32'd3);
        if (n == 4) return rd;
        mask = (n == 1) ? 32'hFF : 32'hFFFF;
        v = (rd >> (8 * ln)) & mask;
        if (!uns && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // One instruction through the stage. Called and returns at posedge+1.
    // ack_at: BUSY cycle (1-based) in which dm_ack is raised; > TO means never.
    task automatic txn(input logic [1:0] m, input logic [1:0] sz, input logic uns,
                       input logic [1:0] wb, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rdat);
        bit mem;
        bit store;
        bit got;
        mem   = (m != 2'b00);
        store = m[0];
        got   = 1'b0;
        EX_M = m; EX_size = sz; EX_unsigned = uns; EX_WB = wb; EX_rd = rd;
        EX_aluResult = a; EX_writeData = wd; dm_ack = 1'b0;
        @(negedge clk);
        if (!mem) begin
            chk("pass_stall", 32'(stall), 32'd0);
            chk("pass_wb", 32'(MEM_WB), 32'(wb));
            chk("pass_rd", 32'(MEM_rd), 32'(rd));
            chk("pass_addr", MEM_address, a);
            chk("pass_data", MEM_data, 32'd0);
            chk("pass_req", 32'(dm_req), 32'd0);
            @(posedge clk); #1;
            return;
        end
        if (m_misaligned(sz, a)) begin
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_wb", 32'(MEM_WB), 32'd0);
            chk("mis_rd", 32'(MEM_rd), 32'd0);
            @(posedge clk); #1;
            EX_M = 2'b00;
            @(negedge clk);
            chk("mis_pulse", 32'(misalign), 32'd1);
            chk("mis_req", 32'(dm_req), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("mis_pulse_end", 32'(misalign), 32'd0);
            @(posedge clk); #1;
            return;
        end
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_wb", 32'(MEM_WB), 32'd0);
        chk("idle_rd", 32'(MEM_rd), 32'd0);
        chk("idle_req", 32'(dm_req), 32'd0);
        for (int i = 1; i <= TO; i++) begin
            @(posedge clk); #1;
            dm_ack   = (i == ack_at);
            dm_rdata = (i == ack_at) ? rdat : $urandom;
            @(negedge clk);
            chk("busy_req", 32'(dm_req), 32'd1);
            chk("busy_we", 32'(dm_we), 32'(store));
            chk("busy_addr", dm_addr, a & 32'hFFFF_FFFC);
            chk("busy_be", 32'(dm_be), 32'(m_be(sz, a)));
            chk("busy_wdata", dm_wdata, store ? m_wdata(sz, wd) : dm_wdata);
            chk("busy_stall", 32'(stall), 32'd1);
            chk("busy_wb", 32'(MEM_WB), 32'd0);
            chk("busy_buserr", 32'(bus_err), 32'd0);
            if (i == ack_at) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        dm_ack = 1'b0; dm_rdata = $urandom;
        @(negedge clk);
        chk("end_req", 32'(dm_req), 32'd0);
        chk("end_stall", 32'(stall), 32'd0);
        chk("end_buserr", 32'(bus_err), 32'(!got));
        if (got) begin
            chk("done_wb", 32'(MEM_WB), 32'(wb));
            chk("done_rd", 32'(MEM_rd), 32'(rd));
            chk("done_data", MEM_data, store ? 32'd0 : m_load(rdat, a, sz, uns));
            chk("done_addr", MEM_address, a);
        end else begin
            chk("abort_wb", 32'(MEM_WB), 32'd0);
            chk("abort_rd", 32'(MEM_rd), 32'd0);
            chk("abort_data", MEM_data, 32'd0);
        end
        @(posedge clk); #1;
        EX_M = 2'b00;
        @(negedge clk);
        chk("after_stall", 32'(stall), 32'd0);
        chk("after_buserr", 32'(bus_err), 32'd0);
        chk("after_req", 32'(dm_req), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0]  r_m;
        logic [1:0]  r_sz;
        logic [31:0] r_a;
        int          r_ack;

        rst = 1'b0;
        EX_M = 2'b00; EX_size = 2'b00; EX_unsigned = 1'b0; EX_WB = 2'b00; EX_rd = 5'd0;
        EX_aluResult = 32'h0; EX_writeData = 32'h0; dm_rdata = 32'h0; dm_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_we", 32'(dm_we), 32'd0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_be", 32'(dm_be), 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_buserr", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_data", MEM_data, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Non-memory pass-through
        txn(2'b00, 2'b10, 1'b0, 2'b10, 5'd5, 32'h1234, 32'h0, 0, 32'h0);
        // LB signed / unsigned at 0x103, ack in 3rd BUSY cycle
        txn(2'b10, 2'b00, 1'b0, 2'b11, 5'd7, 32'h103, 32'h0, 3, 32'h80FF_FF00);
        txn(2'b10, 2'b00, 1'b1, 2'b11, 5'd7, 32'h103, 32'h0, 3, 32'h80FF_FF00);
        // SH at 0x202, immediate ack
        txn(2'b01, 2'b01, 1'b0, 2'b00, 5'd0, 32'h202, 32'hABCD_1234, 1, 32'h0);
        // LW misaligned
        txn(2'b10, 2'b10, 1'b0, 2'b11, 5'd9, 32'h105, 32'h0, 1, 32'h0);
        // LW with no ack -> timeout, then ack on the last count
        txn(2'b10, 2'b10, 1'b0, 2'b11, 5'd3, 32'h300, 32'h0, TO + 1, 32'h0);
        txn(2'b10, 2'b10, 1'b0, 2'b11, 5'd3, 32'h300, 32'h0, TO, 32'hDEAD_BEEF);
        // Both M bits set -> store; reserved size treated as word
        txn(2'b11, 2'b11, 1'b0, 2'b01, 5'd4, 32'h410, 32'h1357_9BDF, 2, 32'hFFFF_FFFF);
        // Signed halfword load in the upper lane
        txn(2'b10, 2'b01, 1'b0, 2'b11, 5'd6, 32'h522, 32'h0, 1, 32'h9ABC_0000);

        // Stray ack while idle is ignored
        EX_M = 2'b00; dm_ack = 1'b1;
        @(negedge clk);
        chk("stray_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        @(negedge clk);
        chk("stray_req", 32'(dm_req), 32'd0);
        chk("stray_data", MEM_data, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset while BUSY
        EX_M = 2'b10; EX_size = 2'b10; EX_aluResult = 32'h40;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_req_before", 32'(dm_req), 32'd1);
        #2;
        rst = 1'b0;
        EX_M = 2'b00;
        #1;
        chk("rb_req", 32'(dm_req), 32'd0);
        chk("rb_stall", 32'(stall), 32'd0);
        chk("rb_be", 32'(dm_be), 32'd0);
        chk("rb_addr", dm_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb_after_req", 32'(dm_req), 32'd0);
        chk("rb_after_stall", 32'(stall), 32'd0);
        chk("rb_after_data", MEM_data, 32'd0);
        chk("rb_after_buserr", 32'(bus_err), 32'd0);
        @(posedge clk); #1;

        // Randomized instructions
        for (int k = 0; k < 40; k++) begin
            r_m   = 2'($urandom_range(0, 3));
            r_sz  = 2'($urandom_range(0, 3));
            r_a   = $urandom;
            if ($urandom_range(0, 1) == 1) r_a = r_a & ~32'd3;
            r_ack = int'($urandom_range(1, TO + 1));
            txn(r_m, r_sz, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), r_a, $urandom, r_ack, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
